// File: rtl/pkt_ser.sv
// Packet serialiser: captures a parallel word and emits LANES bits per enabled beat.
// A one-deep holding register lets the next packet follow with no idle cycle.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_IDLE  | no packet in flight; dout=0, waiting for pkt_rec
// ST_SHIFT | packet in sr being emitted, one beat per pkt_flg=1 edge
module pkt_ser #(
   parameter int DATA_W    = 64,
   parameter int LANES     = 1,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] din,
   input  logic              pkt_rec,
   input  logic              pkt_flg,
   output logic [LANES-1:0]  dout,
   output logic              dout_vld,
   output logic              busy,
   output logic              done,
   output logic              ovf
);

   localparam int BEATS = DATA_W / LANES;
   localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BEATS - 1);

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_SHIFT = 1'b1
   } state_t;

   state_t            state_q, state_d;
   logic [DATA_W-1:0] sr_q, sr_d;
   logic [DATA_W-1:0] hr_q, hr_d;
   logic              hr_full_q, hr_full_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              done_q, done_d;
   logic              ovf_q, ovf_d;

   logic [DATA_W-1:0] sr_shifted;
   logic              shift_edge;
   logic              last_beat;
   logic              hr_to_sr;
   logic              direct_reload;

   assign shift_edge    = (state_q == ST_SHIFT) & pkt_flg;
   assign last_beat     = shift_edge & (cnt_q == LAST_CNT);
   assign hr_to_sr      = last_beat & hr_full_q;
   assign direct_reload = last_beat & ~hr_full_q & pkt_rec;

   // Zero fill; with LANES==DATA_W the whole word clears on the single beat.
   assign sr_shifted = MSB_FIRST ? (sr_q << LANES) : (sr_q >> LANES);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (pkt_rec) begin
               state_d = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            if (last_beat && !hr_full_q && !pkt_rec) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      dout     = MSB_FIRST ? sr_q[DATA_W-1 -: LANES] : sr_q[LANES-1:0];
      dout_vld = (state_q == ST_SHIFT);
      busy     = (state_q == ST_SHIFT) | hr_full_q;
      done     = done_q;
      ovf      = ovf_q;
   end

   always_comb begin
      sr_d      = sr_q;
      hr_d      = hr_q;
      hr_full_d = hr_full_q;
      cnt_d     = cnt_q;
      done_d    = 1'b0;
      ovf_d     = 1'b0;

      if (state_q == ST_IDLE) begin
         if (pkt_rec) begin
            sr_d  = din;
            cnt_d = '0;
         end
      end else begin
         if (shift_edge) begin
            sr_d  = sr_shifted;
            cnt_d = cnt_q + CNT_W'(1);
         end

         if (last_beat) begin
            done_d = 1'b1;
            cnt_d  = '0;
            if (hr_full_q) begin
               sr_d      = hr_q;
               hr_full_d = 1'b0;
            end else if (pkt_rec) begin
               sr_d = din;
            end
         end

         // A load on the edge that empties hr refills it instead of dropping.
         if (pkt_rec && !direct_reload) begin
            if (!hr_full_q || hr_to_sr) begin
               hr_d      = din;
               hr_full_d = 1'b1;
            end else begin
               ovf_d = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sr_q      <= '0;
         hr_q      <= '0;
         hr_full_q <= 1'b0;
         cnt_q     <= '0;
         done_q    <= 1'b0;
         ovf_q     <= 1'b0;
      end else begin
         sr_q      <= sr_d;
         hr_q      <= hr_d;
         hr_full_q <= hr_full_d;
         cnt_q     <= cnt_d;
         done_q    <= done_d;
         ovf_q     <= ovf_d;
      end
   end

endmodule

// File: tb/tb_pkt_ser.sv
// Bench for pkt_ser: two instances (1-lane MSB-first, 4-lane LSB-first) share stimulus
// and are compared every cycle against a packet-level reference model.
module tb_pkt_ser;

   logic        clk = 1'b0;
   logic        rst;
   logic [63:0] din;
   logic        pkt_rec;
   logic        pkt_flg;

   logic [0:0]  dout_a;
   logic        vld_a, busy_a, done_a, ovf_a;
   logic [3:0]  dout_b;
   logic        vld_b, busy_b, done_b, ovf_b;

   int total = 0;
   int bad   = 0;
   int n_done_a = 0;
   int n_ovf_a  = 0;

   // reference model: packet in flight, beat index, held packet
   bit          m_act  [2];
   int          m_k    [2];
   logic [63:0] m_cur  [2];
   bit          m_hv   [2];
   logic [63:0] m_held [2];
   bit          m_done [2];
   bit          m_ovf  [2];
   int          lanes  [2] = '{1, 4};
   bit          msbf   [2] = '{1'b1, 1'b0};

   always #5 clk = ~clk;

   pkt_ser #(.DATA_W(64), .LANES(1), .MSB_FIRST(1'b1)) u_a (
      .clk(clk), .rst(rst), .din(din), .pkt_rec(pkt_rec), .pkt_flg(pkt_flg),
      .dout(dout_a), .dout_vld(vld_a), .busy(busy_a), .done(done_a), .ovf(ovf_a)
   );

   pkt_ser #(.DATA_W(64), .LANES(4), .MSB_FIRST(1'b0)) u_b (
      .clk(clk), .rst(rst), .din(din), .pkt_rec(pkt_rec), .pkt_flg(pkt_flg),
      .dout(dout_b), .dout_vld(vld_b), .busy(busy_b), .done(done_b), .ovf(ovf_b)
   );

   function automatic logic [63:0] beat_of(logic [63:0] p, int k, int l, bit msb);
      int          sh;
      logic [63:0] mask;
      sh   = msb ? (64 - l * (k + 1)) : (l * k);
      mask = (64'd1 << l) - 64'd1;
      return (p >> sh) & mask;
   endfunction

   task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         m_act[i] = 0; m_k[i] = 0; m_cur[i] = '0;
         m_hv[i] = 0; m_held[i] = '0; m_done[i] = 0; m_ovf[i] = 0;
      end
   endtask

   task automatic model_edge(bit rec, bit flg, logic [63:0] d);
      for (int i = 0; i < 2; i++) begin
         int beats;
         beats     = 64 / lanes[i];
         m_done[i] = 0;
         m_ovf[i]  = 0;
         if (!m_act[i]) begin
            if (rec) begin
               m_act[i] = 1; m_cur[i] = d; m_k[i] = 0;
            end
         end else if (flg && m_k[i] == beats - 1) begin
            m_done[i] = 1;
            if (m_hv[i]) begin
               m_cur[i] = m_held[i]; m_k[i] = 0;
               if (rec) m_held[i] = d;
               else     m_hv[i] = 0;
            end else if (rec) begin
               m_cur[i] = d; m_k[i] = 0;
            end else begin
               m_act[i] = 0;
            end
         end else begin
            if (flg) m_k[i]++;
            if (rec) begin
               if (!m_hv[i]) begin
                  m_hv[i] = 1; m_held[i] = d;
               end else begin
                  m_ovf[i] = 1;
               end
            end
         end
      end
   endtask

   task automatic check_all();
      logic [63:0] o_dout [2];
      logic        o_vld [2], o_busy [2], o_done [2], o_ovf [2];
      o_dout[0] = 64'(dout_a); o_vld[0] = vld_a; o_busy[0] = busy_a; o_done[0] = done_a; o_ovf[0] = ovf_a;
      o_dout[1] = 64'(dout_b); o_vld[1] = vld_b; o_busy[1] = busy_b; o_done[1] = done_b; o_ovf[1] = ovf_b;
      for (int i = 0; i < 2; i++) begin
         logic [63:0] e_dout;
         e_dout = m_act[i] ? beat_of(m_cur[i], m_k[i], lanes[i], msbf[i]) : 64'd0;
         chk($sformatf("dout%0d", i), o_dout[i], e_dout);
         chk($sformatf("vld%0d", i), 64'(o_vld[i]), 64'(m_act[i]));
         chk($sformatf("busy%0d", i), 64'(o_busy[i]), 64'(m_act[i] | m_hv[i]));
         chk($sformatf("done%0d", i), 64'(o_done[i]), 64'(m_done[i]));
         chk($sformatf("ovf%0d", i), 64'(o_ovf[i]), 64'(m_ovf[i]));
      end
      n_done_a += int'(done_a);
      n_ovf_a  += int'(ovf_a);
   endtask

   task automatic step(bit rec, bit flg, logic [63:0] d);
      pkt_rec = rec;
      pkt_flg = flg;
      din     = d;
      @(posedge clk);
      model_edge(rec, flg, d);
      #1;
      check_all();
   endtask

   task automatic clr_counts();
      n_done_a = 0;
      n_ovf_a  = 0;
   endtask

   initial begin
      rst = 1'b0; pkt_rec = 1'b0; pkt_flg = 1'b0; din = '0;
      model_reset();
      #12;
      check_all();
      chk("rst_dout_a", 64'(dout_a), 64'd0);
      chk("rst_busy_a", 64'(busy_a), 64'd0);
      @(negedge clk);
      rst = 1'b1;

      // 0xAAAA... on 1 lane, flag held high: alternating bits, one done after 64 beats
      clr_counts();
      step(1'b1, 1'b0, 64'hAAAA_AAAA_AAAA_AAAA);
      chk("aa_first_bit", 64'(dout_a), 64'd1);
      repeat (64) step(1'b0, 1'b1, '0);
      chk("aa_done_cycle65", 64'(done_a), 64'd1);
      step(1'b0, 1'b1, '0);
      chk("aa_idle_vld", 64'(vld_a), 64'd0);
      chk("aa_done_count", 64'(n_done_a), 64'd1);

      // nibble order on the 4-lane LSB-first instance
      step(1'b1, 1'b1, 64'h0123_4567_89AB_CDEF);
      chk("nib_first", 64'(dout_b), 64'hF);
      step(1'b0, 1'b1, '0);
      chk("nib_second", 64'(dout_b), 64'hE);
      repeat (70) step(1'b0, 1'b1, '0);

      // stall: 5 idle flag cycles after beat 10, total 69 cycles
      clr_counts();
      step(1'b1, 1'b0, {$urandom(), $urandom()});
      repeat (10) step(1'b0, 1'b1, '0);
      repeat (5)  step(1'b0, 1'b0, '0);
      repeat (53) step(1'b0, 1'b1, '0);
      chk("stall_no_early_done", 64'(n_done_a), 64'd0);
      step(1'b0, 1'b1, '0);
      chk("stall_done_at_69", 64'(done_a), 64'd1);
      repeat (3) step(1'b0, 1'b1, '0);

      // back-to-back: B held at beat 3, C direct reload on B's last edge
      clr_counts();
      step(1'b1, 1'b0, 64'hA5A5_0000_FFFF_1234);
      repeat (3) step(1'b0, 1'b1, '0);
      step(1'b1, 1'b1, 64'hDEAD_BEEF_CAFE_F00D);
      repeat (60) step(1'b0, 1'b1, '0);
      chk("b2b_vld_after_a", 64'(vld_a), 64'd1);
      repeat (63) step(1'b0, 1'b1, '0);
      step(1'b1, 1'b1, 64'h0F1E_2D3C_4B5A_6978);
      repeat (64) step(1'b0, 1'b1, '0);
      step(1'b0, 1'b1, '0);
      chk("b2b_done_count", 64'(n_done_a), 64'd3);
      chk("b2b_no_ovf", 64'(n_ovf_a), 64'd0);

      // overflow: B held, C dropped
      clr_counts();
      step(1'b1, 1'b0, 64'h1111_2222_3333_4444);
      repeat (2) step(1'b0, 1'b1, '0);
      step(1'b1, 1'b1, 64'h5555_6666_7777_8888);
      repeat (2) step(1'b0, 1'b1, '0);
      step(1'b1, 1'b1, 64'h9999_AAAA_BBBB_CCCC);
      chk("ovf_pulse", 64'(ovf_a), 64'd1);
      repeat (140) step(1'b0, 1'b1, '0);
      chk("ovf_count", 64'(n_ovf_a), 64'd1);
      chk("ovf_done_count", 64'(n_done_a), 64'd2);

      // reset at beat 20 with hr full
      step(1'b1, 1'b0, {$urandom(), $urandom()});
      repeat (19) step(1'b0, 1'b1, '0);
      step(1'b1, 1'b1, {$urandom(), $urandom()});
      chk("pre_rst_busy", 64'(busy_a), 64'd1);
      #3 rst = 1'b0;
      #1;
      model_reset();
      check_all();
      chk("midrst_vld_a", 64'(vld_a), 64'd0);
      @(negedge clk);
      rst = 1'b1;
      repeat (5) step(1'b0, 1'b1, '0);
      chk("post_rst_idle", 64'(vld_a | vld_b), 64'd0);

      // randomized traffic
      for (int n = 0; n < 3000; n++) begin
         bit r, f;
         r = ($urandom_range(0, 15) == 0);
         f = ($urandom_range(0, 9) != 0);
         step(r, f, {$urandom(), $urandom()});
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/pkt_ser.md
# pkt_ser

Parametrised packet serialiser, successor to the 64-bit packet register. It captures a parallel packet word on a load strobe and shifts it out LANES bits per enabled cycle, MSB-first or LSB-first. A one-deep holding buffer lets the next packet be accepted during transmission, so packets stream back-to-back with no idle cycle. It sits between the packet assembly logic and the serial link driver.

## Interface
- DATA_W, 64, packet width in bits.
- LANES, 1, bits emitted per shift beat; must divide DATA_W.
- MSB_FIRST, 1, 1 = emit from the MSB end, 0 = from the LSB end.
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset; asynchronous, active-low (asserted at 0).
- din  in  DATA_W  packet data, sampled on edges where pkt_rec=1.
- pkt_rec  in  1  load strobe; one packet per high cycle.
- pkt_flg  in  1  shift enable; 0 stalls the output on the current beat.
- dout  out  LANES  current serial beat.
- dout_vld  out  1  high while dout carries packet data.
- busy  out  1  high while transmitting or while the holding buffer is full.
- done  out  1  one-cycle pulse after the last beat of a packet shifts out.
- ovf  out  1  one-cycle pulse when a load is dropped.

## Operation
- BEATS = DATA_W/LANES. Beat counter cnt is $clog2(BEATS) bits wide, min 1.
- Storage: shift register sr[DATA_W-1:0], holding register hr, flag hr_full.
- The state machine has two states, IDLE and SHIFT.
- IDLE:
  - pkt_rec=1: sr<=din, cnt<=0, go to SHIFT.
  - pkt_flg is ignored in IDLE.
- SHIFT, on a pkt_flg=1 edge ("shift edge"):
  - MSB_FIRST=1: sr shifts left by LANES.
  - MSB_FIRST=0: sr shifts right by LANES.
  - Vacated bits fill with 0. cnt increments.
- SHIFT, pkt_flg=0: sr and cnt hold. dout stays stable.
- Last beat is a shift edge with cnt==BEATS-1. On that edge:
  - done is set for the next cycle.
  - hr_full=1: sr<=hr, hr_full<=0, cnt<=0, stay in SHIFT.
  - else pkt_rec=1 on the same edge: sr<=din, cnt<=0, stay in SHIFT (direct reload).
  - else go to IDLE.
- pkt_rec in SHIFT, not the direct-reload case:
  - hr_full=0: hr<=din, hr_full<=1.
  - hr_full=1 and the same edge is a last beat that transfers hr into sr: hr<=din, hr_full stays 1. No drop.
  - hr_full=1 otherwise: din is dropped, ovf is set for the next cycle, hr is unchanged.
- dout = sr[DATA_W-1 -: LANES] when MSB_FIRST=1, else sr[LANES-1:0].
- dout_vld = (state==SHIFT).
- busy = (state==SHIFT) | hr_full.
- With LANES=DATA_W (BEATS=1): every shift edge is a last beat.

## Timing
- Reset values: sr=0, hr=0, hr_full=0, cnt=0, state=IDLE.
- Outputs during reset: dout=0, dout_vld=0, busy=0, done=0, ovf=0.
- Reset asserted mid-packet: the packet and any held packet are discarded immediately. No done pulse.
- Load latency: pkt_rec at edge N puts the first beat on dout after edge N, with dout_vld=1.
- Beat k (0-based) is presented until the k-th shift edge after the load.
- An uninterrupted packet takes BEATS cycles.
- done is high for exactly the cycle after the last shift edge.
- Back-to-back packets (held or direct reload): the new packet's first beat appears in the cycle right after the previous packet's last shift edge. No gap; dout_vld stays 1.
- ovf is high for exactly the cycle after the drop edge.

## Test plan
- DATA_W=64, LANES=1, MSB_FIRST=1, load 0xAAAAAAAAAAAAAAAA, pkt_flg held 1 -> dout reads 1,0,1,0,… for 64 cycles; done pulses once in cycle 65; then IDLE with dout_vld=0.
- LANES=4, MSB_FIRST=0, load 0x0123456789ABCDEF -> nibbles F,E,D,…,1,0 over 16 beats; done pulses once.
- Stall: LANES=1, insert pkt_flg=0 for 5 cycles after beat 10 -> beat 10 value held for 6 cycles; total packet time is 69 cycles; bit order intact.
- Back-to-back: load A, then load B at beat 3 (B held), then a third load C on B's last edge -> A, B, C stream contiguously; three done pulses; no ovf.
- Overflow: load A; load B at beat 2; load C at beat 5 -> ovf pulses once after C's edge; output is A then B only; busy deasserts the cycle after B's last edge.
- Reset mid-packet: assert rst=0 at beat 20 with the holding buffer full -> all outputs 0 immediately; after release, nothing is emitted until a new pkt_rec.
